// File: rtl/nibbler_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : nibbler_fetch_sequencer
//  Brief    : Fetch/execute control FSM for the 4-bit CPU. Fetches 1/2-byte
//             instructions into the IR, drives PC inc/load, resolves jumps,
//             and supports run / halt / single-step.
//             Define SEQ_TRACE_EN to build the retired-instruction counter.
//  Revision : 1.0 - initial release
// ============================================================================
module nibbler_fetch_sequencer #(
   parameter logic [3:0] OPC_JMP = 4'hC,
   parameter logic [3:0] OPC_JC  = 4'hD,
   parameter logic [3:0] OPC_JZ  = 4'hE,
   parameter logic [3:0] OPC_JNZ = 4'hF,
   parameter logic [3:0] OPC_HLT = 4'h7
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        run,
   input  logic        step,
   input  logic        halt_req,
   input  logic [7:0]  rom_data,
   input  logic        carry_flag,
   input  logic        zero_flag,
   output logic        inc_pc,
   output logic        load_pc,
   output logic [11:0] load_addr,
   output logic [3:0]  ir_op,
   output logic [3:0]  ir_arg,
   output logic [7:0]  ir_lo,
   output logic        exec_strobe,
   output logic        halted,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH1 = 3'd1,
      ST_FETCH2 = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_step_latch;
   logic        w_step_latch_nxt;
   logic [3:0]  r_ir_op;
   logic [3:0]  r_ir_arg;
   logic [7:0]  r_ir_lo;
   logic [11:0] r_load_addr;
   logic        w_jump_taken;

   assign ir_op  = r_ir_op;
   assign ir_arg = r_ir_arg;
   assign ir_lo  = r_ir_lo;

   // Flags are only meaningful while in EXEC; the decode is gated there.
   always_comb begin
      w_jump_taken = (r_ir_op == OPC_JMP)
                   | ((r_ir_op == OPC_JC)  &  carry_flag)
                   | ((r_ir_op == OPC_JZ)  &  zero_flag)
                   | ((r_ir_op == OPC_JNZ) & ~zero_flag);
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_state      <= ST_IDLE;
         r_step_latch <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_step_latch <= w_step_latch_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_step_latch_nxt = r_step_latch;
      inc_pc           = 1'b0;
      load_pc          = 1'b0;
      load_addr        = r_load_addr;
      exec_strobe      = 1'b0;
      halted           = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (run) w_state_nxt = ST_FETCH1;
         end
         ST_FETCH1: begin
            inc_pc      = 1'b1;
            w_state_nxt = rom_data[7] ? ST_FETCH2 : ST_EXEC;
         end
         ST_FETCH2: begin
            inc_pc      = 1'b1;
            w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            exec_strobe = 1'b1;
            if (w_jump_taken) begin
               load_pc   = 1'b1;
               load_addr = {r_ir_arg, r_ir_lo};
            end
            // Any entry to HALT consumes a pending step so it cannot leak
            // into a later run.
            if ((r_ir_op == OPC_HLT) || halt_req || r_step_latch) begin
               w_state_nxt      = ST_HALT;
               w_step_latch_nxt = 1'b0;
            end else if (!run) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_FETCH1;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
            if (step) begin
               w_step_latch_nxt = 1'b1;
               w_state_nxt      = ST_FETCH1;
            end else if (run && !halt_req) begin
               w_state_nxt = ST_FETCH1;
            end
         end
         default: begin
            w_state_nxt      = ST_IDLE;
            w_step_latch_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_ir_op  <= 4'h0;
         r_ir_arg <= 4'h0;
         r_ir_lo  <= 8'h00;
      end else begin
         if (r_state == ST_FETCH1) begin
            r_ir_op  <= rom_data[7:4];
            r_ir_arg <= rom_data[3:0];
         end
         if (r_state == ST_FETCH2) begin
            r_ir_lo <= rom_data;
         end
      end
   end

   // load_addr holds the last taken target between jumps.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_load_addr <= 12'h000;
      end else if (load_pc) begin
         r_load_addr <= load_addr;
      end
   end

`ifdef SEQ_TRACE_EN
   logic [15:0] r_instr_count;

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_instr_count <= 16'h0000;
      end else if ((r_state == ST_EXEC) && (r_instr_count != 16'hFFFF)) begin
         r_instr_count <= r_instr_count + 16'd1;
      end
   end

   assign instr_count = r_instr_count;
`else
   assign instr_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibbler_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibbler_fetch_sequencer
//  Brief    : Directed vector bench for nibbler_fetch_sequencer with a ROM and
//             PC model around the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nibbler_fetch_sequencer;

   logic        clk = 1'b0;
   logic        Rst;
   logic        run;
   logic        step;
   logic        halt_req;
   logic [7:0]  rom_data;
   logic        carry_flag;
   logic        zero_flag;
   logic        inc_pc;
   logic        load_pc;
   logic [11:0] load_addr;
   logic [3:0]  ir_op;
   logic [3:0]  ir_arg;
   logic [7:0]  ir_lo;
   logic        exec_strobe;
   logic        halted;
   logic [15:0] instr_count;

   logic [7:0]  rom [0:4095];
   logic [11:0] pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nibbler_fetch_sequencer dut (
      .clk         (clk),
      .Rst         (Rst),
      .run         (run),
      .step        (step),
      .halt_req    (halt_req),
      .rom_data    (rom_data),
      .carry_flag  (carry_flag),
      .zero_flag   (zero_flag),
      .inc_pc      (inc_pc),
      .load_pc     (load_pc),
      .load_addr   (load_addr),
      .ir_op       (ir_op),
      .ir_arg      (ir_arg),
      .ir_lo       (ir_lo),
      .exec_strobe (exec_strobe),
      .halted      (halted),
      .instr_count (instr_count)
   );

   assign rom_data = rom[pc];

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst)          pc <= 12'h000;
      else if (load_pc) pc <= load_addr;
      else if (inc_pc)  pc <= pc + 12'd1;
   end

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic        c;
      logic        z;
      logic        two;
      logic        exp_load;
      logic [11:0] exp_addr;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
   endtask

   task automatic do_reset();
      run        = 1'b0;
      step       = 1'b0;
      halt_req   = 1'b0;
      carry_flag = 1'b0;
      zero_flag  = 1'b0;
      Rst        = 1'b1;
      tick();
      Rst        = 1'b0;
   endtask

   initial begin
      int          n;
      logic [11:0] exp_pc;

      clear_rom();
      do_reset();
      check("rst_inc_pc", inc_pc, 0);
      check("rst_halted", halted, 0);
      check("rst_ir_op", ir_op, 0);
      check("rst_load_addr", load_addr, 0);
      check("rst_count", instr_count, 0);

      //              b0     b1     c  z  two ld  addr
      vecs[0] = '{8'h12, 8'h00, 0, 0, 0, 0, 12'h000};
      vecs[1] = '{8'hC5, 8'hA0, 0, 0, 1, 1, 12'h5A0};
      vecs[2] = '{8'hD3, 8'h10, 0, 0, 1, 0, 12'h000};
      vecs[3] = '{8'hD3, 8'h10, 1, 0, 1, 1, 12'h310};
      vecs[4] = '{8'hE3, 8'h10, 0, 0, 1, 0, 12'h000};
      vecs[5] = '{8'hE3, 8'h10, 0, 1, 1, 1, 12'h310};
      vecs[6] = '{8'hF3, 8'h10, 0, 0, 1, 1, 12'h310};
      vecs[7] = '{8'hF3, 8'h10, 0, 1, 1, 0, 12'h000};
      vecs[8] = '{8'hA5, 8'h77, 1, 1, 1, 0, 12'h000};

      for (int i = 0; i < 9; i++) begin
         do_reset();
         clear_rom();
         rom[0]     = vecs[i].b0;
         rom[1]     = vecs[i].b1;
         carry_flag = vecs[i].c;
         zero_flag  = vecs[i].z;
         run        = 1'b1;
         tick();
         check("vec_f1_inc", inc_pc, 1);
         check("vec_f1_exec", exec_strobe, 0);
         tick();
         if (vecs[i].two) begin
            check("vec_f2_inc", inc_pc, 1);
            tick();
         end
         check("vec_exec", exec_strobe, 1);
         check("vec_exec_inc", inc_pc, 0);
         check("vec_load_pc", load_pc, vecs[i].exp_load);
         check("vec_load_addr", load_addr, vecs[i].exp_addr);
         check("vec_ir_op", ir_op, vecs[i].b0[7:4]);
         check("vec_ir_arg", ir_arg, vecs[i].b0[3:0]);
         if (vecs[i].two) check("vec_ir_lo", ir_lo, vecs[i].b1);
         run = 1'b0;
         exp_pc = vecs[i].exp_load ? vecs[i].exp_addr : (vecs[i].two ? 12'd2 : 12'd1);
         tick();
         check("vec_next_pc", pc, exp_pc);
         check("vec_idle_inc", inc_pc, 0);
      end

      // Reset in the middle of FETCH2
      do_reset();
      clear_rom();
      rom[0] = 8'hC5;
      rom[1] = 8'hA0;
      run = 1'b1;
      tick();
      tick();
      check("midrst_f2_inc", inc_pc, 1);
      Rst = 1'b1;
      #1;
      check("midrst_inc", inc_pc, 0);
      check("midrst_exec", exec_strobe, 0);
      check("midrst_halted", halted, 0);
      check("midrst_ir_op", ir_op, 0);
      check("midrst_ir_arg", ir_arg, 0);
      check("midrst_ir_lo", ir_lo, 0);
      check("midrst_load_addr", load_addr, 0);
      Rst = 1'b0;
      run = 1'b0;
      tick();
      check("midrst_idle_inc", inc_pc, 0);
      check("midrst_idle_exec", exec_strobe, 0);

      // Continuous run of two 1-byte instructions
      do_reset();
      clear_rom();
      rom[0] = 8'h12;
      rom[1] = 8'h34;
      run = 1'b1;
      tick();
      check("seq_f1a", inc_pc, 1);
      tick();
      check("seq_exa", exec_strobe, 1);
      check("seq_exa_op", {ir_op, ir_arg}, 8'h12);
      tick();
      check("seq_f1b", inc_pc, 1);
      check("seq_f1b_pc", pc, 1);
      tick();
      check("seq_exb", exec_strobe, 1);
      check("seq_exb_op", {ir_op, ir_arg}, 8'h34);
      run = 1'b0;
      tick();
      check("seq_end_pc", pc, 2);

      // Jump then a non-jump: load_addr keeps the previous target
      do_reset();
      clear_rom();
      rom[0] = 8'hC5;
      rom[1] = 8'hA0;
      rom[12'h5A0] = 8'h12;
      run = 1'b1;
      tick();
      tick();
      tick();
      check("hold_jmp", load_pc, 1);
      tick();
      check("hold_pc", pc, 12'h5A0);
      tick();
      check("hold_nojmp", load_pc, 0);
      check("hold_addr", load_addr, 12'h5A0);
      check("hold_op", ir_op, 1);
      run = 1'b0;
      tick();

      // HLT, single step, resume, halt_req, step priority over run
      do_reset();
      clear_rom();
      rom[0] = 8'h70;
      rom[1] = 8'h12;
      rom[2] = 8'h34;
      run = 1'b1;
      tick();
      tick();
      check("hlt_exec_op", ir_op, 7);
      run = 1'b0;
      tick();
      check("hlt_halted", halted, 1);
      check("hlt_inc", inc_pc, 0);
      check("hlt_pc", pc, 1);
      tick();
      check("hlt_stay", halted, 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         if (exec_strobe) n++;
         tick();
      end
      check("step_execs", n, 1);
      check("step_halted", halted, 1);
      check("step_pc", pc, 2);
      check("step_op", ir_op, 1);
      run = 1'b1;
      tick();
      check("resume_f1", inc_pc, 1);
      tick();
      check("resume_op", {ir_op, ir_arg}, 8'h34);
      tick();
      halt_req = 1'b1;
      tick();
      check("hreq_completes", exec_strobe, 1);
      tick();
      check("hreq_halted", halted, 1);
      halt_req = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
      check("prio_f1", inc_pc, 1);
      tick();
      check("prio_exec", exec_strobe, 1);
      tick();
      check("prio_halted", halted, 1);
      run = 1'b0;
      tick();

      // Retired-instruction counter
      do_reset();
      clear_rom();
      check("cnt_rst", instr_count, 0);
      run = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      run = 1'b0;
      tick();
`ifdef SEQ_TRACE_EN
      check("cnt_five", instr_count, 5);
      force dut.r_instr_count = 16'hFFFF;
      #1;
      release dut.r_instr_count;
      run = 1'b1;
      tick();
      tick();
      run = 1'b0;
      tick();
      check("cnt_sat", instr_count, 16'hFFFF);
`else
      check("cnt_off", instr_count, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nibbler_fetch_sequencer.md
Name: nibbler_fetch_sequencer

Overview:
- Fetch/execute control FSM for the 4-bit CPU. It drives the program counter's increment and load controls and fetches 1- or 2-byte instructions from program ROM into an instruction register.
- Resolves jumps from ALU flags and supports run, halt and single-step.
- Sits between program ROM/PC and the execute datapath (ALU, RAM, which sample exec_strobe).

Parameters:
OPC_JMP, 4'hC, unconditional jump opcode
OPC_JC, 4'hD, jump if carry_flag=1
OPC_JZ, 4'hE, jump if zero_flag=1
OPC_JNZ, 4'hF, jump if zero_flag=0
OPC_HLT, 4'h7, halt opcode (1-byte)

Ports:
clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-high reset
run  in  1  level; 1 = execute continuously
step  in  1  1-cycle pulse; execute one instruction while halted
halt_req  in  1  level; stop at next instruction boundary
rom_data  in  8  ROM byte at current PC (combinational ROM)
carry_flag  in  1  ALU carry, valid during EXEC
zero_flag  in  1  ALU zero, valid during EXEC
inc_pc  out  1  PC increment enable
load_pc  out  1  PC load enable
load_addr  out  12  PC load value
ir_op  out  4  opcode = byte0[7:4]
ir_arg  out  4  operand = byte0[3:0]
ir_lo  out  8  second byte (2-byte instructions)
exec_strobe  out  1  1-cycle execute pulse
halted  out  1  1 in HALT state
instr_count  out  16  retired-instruction count (see Optional Feature)

Behaviour:
- States: IDLE, FETCH1, FETCH2, EXEC, HALT. Outputs are Moore, decoded from state and IR; registers update on clk rising edge.
- Reset (async, any state, including mid-instruction): state=IDLE; ir_op, ir_arg, ir_lo, instr_count = 0. All strobes 0, halted=0, load_addr=0.
- IDLE: if run=1, go to FETCH1; else stay.
- FETCH1: inc_pc=1. At the edge ending this state, ir_op/ir_arg <= rom_data. Next state is FETCH2 if rom_data[7]=1 (2-byte instruction), else EXEC.
- FETCH2: inc_pc=1. ir_lo <= rom_data. Next state EXEC.
- EXEC: exec_strobe=1.
  - Taken jump: ir_op=OPC_JMP, or OPC_JC with carry_flag=1, or OPC_JZ with zero_flag=1, or OPC_JNZ with zero_flag=0.
  - On a taken jump: load_pc=1 and load_addr={ir_arg, ir_lo}. Otherwise load_pc=0 and load_addr holds its last value.
  - inc_pc is never 1 in EXEC, so inc and load never coincide.
- EXEC next-state priority:
  1. ir_op=OPC_HLT → HALT
  2. halt_req=1 → HALT
  3. step latch set → HALT, clear step latch
  4. run=0 → IDLE
  5. otherwise → FETCH1
- HALT: halted=1.
  - step=1 → set step latch, go to FETCH1.
  - Else run=1 and halt_req=0 → FETCH1.
  - A step pulse has priority over run.
- Latency: a 1-byte instruction takes 2 cycles, a 2-byte instruction takes 3 cycles.
- A 1-byte jump opcode (rom_data[7]=0) is not possible with the default opcodes. If an opcode parameter is overridden to a 1-byte value, ir_lo from the previous 2-byte instruction is used.
- step outside HALT is ignored. Changes to halt_req/run mid-instruction take effect only at the end of EXEC; the instruction always completes.
- The PC wraps 12'hFFF→12'h000; the sequencer needs no special handling for it.

Optional Feature:
- Macro SEQ_TRACE_EN.
- Defined: instr_count increments by 1 at every EXEC cycle and saturates at 16'hFFFF. Reset clears it to 0.
- Undefined: no counter register; instr_count is tied to 16'h0000.

Test Plan:
- Reset mid-FETCH2 → next cycle state IDLE, all outputs 0, halted=0, ir_* = 0.
- run=1, ROM[0]=8'h12, ROM[1]=8'h34 → inc_pc high 1 cycle; exec_strobe with ir_op=1, ir_arg=2; then FETCH1 of ROM[1]; 2 cycles per instruction.
- ROM[0]=8'hC5, ROM[1]=8'hA0 → 2 inc_pc cycles; then EXEC with load_pc=1, load_addr=12'h5A0, inc_pc=0.
- ROM byte 8'hD3, 8'h10: with carry_flag=0, load_pc=0 and fetch continues sequentially. With carry_flag=1, load_addr=12'h310. Repeat for JZ/JNZ with zero_flag both values.
- ROM=8'h70 → after EXEC halted=1 and no inc_pc. Then a step pulse executes exactly one following instruction (one exec_strobe) and returns to halted=1. run=1 with halt_req=0 resumes.
- SEQ_TRACE_EN defined, 5 instructions run → instr_count=5. Force 16'hFFFF and retire one more → stays 16'hFFFF. Undefined → always 0.
